// File: rtl/palindrome_sched_pkg.sv
// ============================================================================
// Module  : palindrome_pkg
// Purpose : Shared types and helpers for the palindrome scheduler slice.
//           Holds the scheduler state encoding, the default detector
//           latency and the requester-ID width helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package palindrome_pkg;

    // Scheduler state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Latency of the stock detector, in clock edges from data_in sample
    // to a valid is_palindrome.
    localparam int c_DET_LAT_DEFAULT = 1;

    // Width of a requester index; at least one bit even for tiny counts.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/palindrome_sched_if.sv
// ============================================================================
// Module  : palindrome_sched_if
// Purpose : Request and response handshake bundle of the palindrome
//           scheduler.
// Signals : req_valid/req_ready/req_data  - per-requester request channel
//           rsp_valid/rsp_ready           - response handshake
//           rsp_id/rsp_is_pal             - response payload
// Modports: master - requesters and response consumer
//           slave  - the scheduler
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface palindrome_sched_if
    import palindrome_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = id_width(NUM_REQ)
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_is_pal;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_is_pal
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_is_pal
    );

endinterface

`default_nettype wire

// File: rtl/palindrome_sched_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin priority rotation. Picks the first
//           asserted request at or above ptr_i, wrapping around.
// Ports   : req_i   (in)  request vector
//           ptr_i   (in)  index with highest priority
//           grant_o (out) one-hot grant, zero when nothing requests
//           idx_o   (out) encoded index of the grant
//           any_o   (out) at least one request present
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import palindrome_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic [ID_W-1:0] w_j;
    logic            w_found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!w_found && req_i[w_j]) begin
                w_found     = 1'b1;
                grant_o[w_j] = 1'b1;
                idx_o       = w_j;
            end
        end
        any_o = w_found;
    end

endmodule

`default_nettype wire

// File: rtl/palindrome_sched.sv
// ============================================================================
// Module  : palindrome_sched
// Purpose : Shares one external registered palindrome detector among
//           NUM_REQ requesters. One word is in flight at a time: grant,
//           wait out the detector latency, return the tagged result, and
//           keep saturating hit/total statistics.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           bus (slave)     - request and response handshakes
//           det_data_o      - registered word to the detector data_in
//           det_result_i    - detector is_palindrome
//           pal_count_o     - palindrome responses delivered
//           total_count_o   - all responses delivered
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module palindrome_sched
    import palindrome_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int DET_LAT = c_DET_LAT_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    palindrome_sched_if.slave bus,
    output logic [DATA_W-1:0] det_data_o,
    input  logic              det_result_i,
    output logic [CNT_W-1:0]  pal_count_o,
    output logic [CNT_W-1:0]  total_count_o
);

    localparam int ID_W = id_width(NUM_REQ);
    // Wait counter must hold DET_LAT plus one spare bit.
    localparam int WC_W = $clog2(DET_LAT + 1) + 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] det_data_q, det_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_is_pal_q, rsp_is_pal_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  pal_cnt_q, pal_cnt_d;
    logic [CNT_W-1:0]  tot_cnt_q, tot_cnt_d;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [DATA_W-1:0]  w_word;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .any_o   (w_any)
    );

    assign w_word = bus.req_data[w_idx*DATA_W +: DATA_W];

    // Grant is offered only while idle, so a grant is always a handshake.
    assign bus.req_ready  = (state_q == ST_IDLE) ? w_grant : '0;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_is_pal = rsp_is_pal_q;
    assign det_data_o     = det_data_q;
    assign pal_count_o    = pal_cnt_q;
    assign total_count_o  = tot_cnt_q;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        det_data_d   = det_data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_is_pal_d = rsp_is_pal_q;
        wait_cnt_d   = wait_cnt_q;
        pal_cnt_d    = pal_cnt_q;
        tot_cnt_d    = tot_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    det_data_d = w_word;
                    rsp_id_d   = w_idx;
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The detector saw det_data one edge after the grant, so
                // its result is ready once DET_LAT further edges passed.
                if (wait_cnt_q == WC_W'(DET_LAT)) begin
                    rsp_is_pal_d = det_result_i;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (tot_cnt_q != c_CNT_MAX) begin
                        tot_cnt_d = tot_cnt_q + 1'b1;
                    end
                    if (rsp_is_pal_q && (pal_cnt_q != c_CNT_MAX)) begin
                        pal_cnt_d = pal_cnt_q + 1'b1;
                    end
                    // Priority moves past the requester just served.
                    rr_ptr_d = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            det_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_is_pal_q <= 1'b0;
            wait_cnt_q   <= '0;
            pal_cnt_q    <= '0;
            tot_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            det_data_q   <= det_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_is_pal_q <= rsp_is_pal_d;
            wait_cnt_q   <= wait_cnt_d;
            pal_cnt_q    <= pal_cnt_d;
            tot_cnt_q    <= tot_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_palindrome_sched.sv
// ============================================================================
// Module  : tb_palindrome_sched
// Purpose : Scoreboard bench for palindrome_sched. Instance 0 uses the
//           default build (4 requesters, DET_LAT=1, 16-bit counters);
//           instance 1 uses DET_LAT=3 with 2-bit counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_palindrome_sched;
    import palindrome_pkg::*;

    localparam int N0 = 4;
    localparam int W  = 8;
    localparam int L0 = 1;
    localparam int C0 = 16;
    localparam int N1 = 2;
    localparam int L1 = 3;
    localparam int C1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst1_n;

    // ---------------- instance 0 ----------------
    palindrome_sched_if #(.NUM_REQ(N0), .DATA_W(W), .ID_W(id_width(N0))) bus0 ();
    logic [W-1:0]  det_data0;
    logic          det_res0 = 1'b0;
    logic [C0-1:0] pal0, tot0;

    palindrome_sched #(.NUM_REQ(N0), .DATA_W(W), .DET_LAT(L0), .CNT_W(C0)) dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus0),
        .det_data_o    (det_data0),
        .det_result_i  (det_res0),
        .pal_count_o   (pal0),
        .total_count_o (tot0)
    );

    // ---------------- instance 1 ----------------
    palindrome_sched_if #(.NUM_REQ(N1), .DATA_W(W), .ID_W(id_width(N1))) bus1 ();
    logic [W-1:0]  det_data1;
    logic          det_res1;
    logic [C1-1:0] pal1, tot1;

    palindrome_sched #(.NUM_REQ(N1), .DATA_W(W), .DET_LAT(L1), .CNT_W(C1)) dut1 (
        .clk           (clk),
        .rst_n         (rst1_n),
        .bus           (bus1),
        .det_data_o    (det_data1),
        .det_result_i  (det_res1),
        .pal_count_o   (pal1),
        .total_count_o (tot1)
    );

    // Reference: a word is a palindrome when it equals its bit reversal.
    function automatic logic ref_pal(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) r[k] = w[W-1-k];
        return r == w;
    endfunction

    // Detector models with the configured latencies.
    always @(posedge clk) det_res0 <= ref_pal(det_data0);
    logic [L1-1:0] pipe1 = '0;
    always @(posedge clk) pipe1 <= {pipe1[L1-2:0], ref_pal(det_data1)};
    assign det_res1 = pipe1[L1-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int   id;
        logic pal;
    } exp_t;

    // ---------------- instance 0 stimulus ----------------
    logic [W-1:0] wq [N0][$];
    int           rdy_mode = 0;

    initial begin : drv0
        logic [N0-1:0] hs;
        bus0.req_valid = '0;
        bus0.req_data  = '0;
        bus0.rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            hs = bus0.req_valid & bus0.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N0; i++) begin
                if (hs[i] && wq[i].size() > 0) void'(wq[i].pop_front());
                if (rst_n && wq[i].size() > 0) begin
                    bus0.req_valid[i]          = 1'b1;
                    bus0.req_data[i*W +: W]    = wq[i][0];
                end else begin
                    bus0.req_valid[i] = 1'b0;
                end
            end
            case (rdy_mode)
                0:       bus0.rsp_ready = 1'b1;
                1:       bus0.rsp_ready = 1'($urandom_range(0, 1));
                default: bus0.rsp_ready = 1'b0;
            endcase
        end
    end

    // ---------------- instance 0 scoreboard/monitor ----------------
    exp_t          sbq[$];
    int            exp_gl[$];
    int            m_ptr = 0, m_pal = 0, m_tot = 0;
    logic          prev_v = 1'b0, prev_r = 1'b0, prev_pal = 1'b0;
    logic [1:0]    prev_id = '0;
    logic [W-1:0]  prev_det = '0;
    bit            cnt_chk = 1'b0;
    int            hs_cyc = 0;

    initial begin : mon0
        int   win, g, j;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_rsp_valid", 32'(bus0.rsp_valid), 0);
                check("rst_rsp_id", 32'(bus0.rsp_id), 0);
                check("rst_rsp_is_pal", 32'(bus0.rsp_is_pal), 0);
                check("rst_det_data", 32'(det_data0), 0);
                check("rst_pal_count", 32'(pal0), 0);
                check("rst_total_count", 32'(tot0), 0);
                check("rst_req_ready", 32'(bus0.req_ready), 0);
                sbq.delete();
                m_ptr = 0; m_pal = 0; m_tot = 0;
                prev_v = 1'b0; prev_r = 1'b0; cnt_chk = 1'b0;
            end else begin
                if (cnt_chk) begin
                    check("pal_count", 32'(pal0), 32'(m_pal));
                    check("total_count", 32'(tot0), 32'(m_tot));
                    cnt_chk = 1'b0;
                end
                if (prev_v && !prev_r) begin
                    check("hold_valid", 32'(bus0.rsp_valid), 1);
                    check("hold_id", 32'(bus0.rsp_id), 32'(prev_id));
                    check("hold_is_pal", 32'(bus0.rsp_is_pal), 32'(prev_pal));
                    check("hold_det_data", 32'(det_data0), 32'(prev_det));
                    check("hold_req_ready", 32'(bus0.req_ready), 0);
                end
                if (prev_v && prev_r) check("rsp_drop", 32'(bus0.rsp_valid), 0);
                if (bus0.rsp_valid && !prev_v) check("latency", 32'(cyc - hs_cyc), 32'(L0 + 1));

                if ((bus0.req_valid & bus0.req_ready) != '0) begin
                    win = -1;
                    for (int k = 0; k < N0; k++) begin
                        j = (m_ptr + k) % N0;
                        if (win < 0 && bus0.req_valid[j]) win = j;
                    end
                    check("grant", 32'(bus0.req_ready), 32'(1 << win));
                    g = 0;
                    for (int k = 0; k < N0; k++) if (bus0.req_ready[k]) g = k;
                    if (exp_gl.size() > 0) check("grant_seq", 32'(g), 32'(exp_gl.pop_front()));
                    e.id  = win;
                    e.pal = ref_pal(bus0.req_data[win*W +: W]);
                    sbq.push_back(e);
                    hs_cyc = cyc + 1;
                end

                if (bus0.rsp_valid && bus0.rsp_ready) begin
                    if (sbq.size() == 0) begin
                        check("rsp_unexpected", 32'(sbq.size()), 1);
                    end else begin
                        e = sbq.pop_front();
                        check("rsp_id", 32'(bus0.rsp_id), 32'(e.id));
                        check("rsp_is_pal", 32'(bus0.rsp_is_pal), 32'(e.pal));
                        if (m_tot < (1 << C0) - 1) m_tot++;
                        if (e.pal && m_pal < (1 << C0) - 1) m_pal++;
                        m_ptr   = (e.id + 1) % N0;
                        cnt_chk = 1'b1;
                    end
                end
                prev_v   = bus0.rsp_valid;
                prev_r   = bus0.rsp_ready;
                prev_id  = bus0.rsp_id;
                prev_pal = bus0.rsp_is_pal;
                prev_det = det_data0;
            end
        end
    end

    // ---------------- instance 1 stimulus and monitor ----------------
    bit   done1 = 1'b0;
    logic sbq1[$];
    int   exp_cnt1[$];
    int   m1_pal = 0, m1_tot = 0, hs1_cyc = 0;
    logic prev1_v = 1'b0;
    bit   cnt1_chk = 1'b0;

    initial begin : drv1
        int        n;
        logic [W-1:0] w;
        bus1.req_valid = '0;
        bus1.req_data  = '0;
        bus1.rsp_ready = 1'b1;
        rst1_n = 1'b0;
        exp_cnt1 = '{1, 2, 3, 3, 3};
        repeat (3) @(posedge clk);
        #2 rst1_n = 1'b1;
        for (int t = 0; t < 11; t++) begin
            w = (t < 5) ? 8'h00 : 8'($urandom);
            @(posedge clk);
            #1;
            bus1.req_valid[0]  = 1'b1;
            bus1.req_data[W-1:0] = w;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus1.req_ready[0] && n < 50);
            check("i1_grant_timeout", 32'(n < 50), 1);
            @(posedge clk);
            #1 bus1.req_valid[0] = 1'b0;
        end
        repeat (20) @(posedge clk);
        done1 = 1'b1;
    end

    initial begin : mon1
        logic ep;
        forever begin
            @(negedge clk);
            if (!rst1_n) begin
                sbq1.delete();
                m1_pal = 0; m1_tot = 0; prev1_v = 1'b0; cnt1_chk = 1'b0;
            end else begin
                if (cnt1_chk) begin
                    check("i1_pal_count", 32'(pal1), 32'(m1_pal));
                    check("i1_total_count", 32'(tot1), 32'(m1_tot));
                    if (exp_cnt1.size() > 0) begin
                        ep = 1'b0;
                        check("i1_sat_seq_pal", 32'(pal1), 32'(exp_cnt1[0]));
                        check("i1_sat_seq_tot", 32'(tot1), 32'(exp_cnt1.pop_front()));
                    end
                    cnt1_chk = 1'b0;
                end
                if (bus1.rsp_valid && !prev1_v) check("i1_latency", 32'(cyc - hs1_cyc), 32'(L1 + 1));
                if ((bus1.req_valid & bus1.req_ready) != '0) begin
                    check("i1_grant", 32'(bus1.req_ready), 1);
                    sbq1.push_back(ref_pal(bus1.req_data[W-1:0]));
                    hs1_cyc = cyc + 1;
                end
                if (bus1.rsp_valid && bus1.rsp_ready) begin
                    if (sbq1.size() == 0) begin
                        check("i1_rsp_unexpected", 32'(sbq1.size()), 1);
                    end else begin
                        ep = sbq1.pop_front();
                        check("i1_rsp_id", 32'(bus1.rsp_id), 0);
                        check("i1_rsp_is_pal", 32'(bus1.rsp_is_pal), 32'(ep));
                        if (m1_tot < (1 << C1) - 1) m1_tot++;
                        if (ep && m1_pal < (1 << C1) - 1) m1_pal++;
                        cnt1_chk = 1'b1;
                    end
                end
                prev1_v = bus1.rsp_valid;
            end
        end
    end

    // ---------------- sequencer ----------------
    function automatic bit wq_empty();
        for (int i = 0; i < N0; i++) if (wq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((!wq_empty() || sbq.size() != 0 || bus0.rsp_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < budget), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin : seq
        int           n;
        logic [W-1:0] r;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single requester, directed words.
        exp_gl = '{0, 0, 0, 0, 0};
        wq[0].push_back(8'hA5); wq[0].push_back(8'hC3); wq[0].push_back(8'hAA);
        wq[0].push_back(8'hF0); wq[0].push_back(8'hCC);
        wait_drain("drain_single", 200);
        check("single_pal_count", 32'(pal0), 2);
        check("single_total_count", 32'(tot0), 5);

        // All requesters continuously valid.
        do_reset();
        exp_gl = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int rep = 0; rep < 2; rep++) begin
            wq[0].push_back(8'h81); wq[1].push_back(8'h18);
            wq[2].push_back(8'h01); wq[3].push_back(8'hFF);
        end
        wait_drain("drain_rr", 300);
        check("rr_pal_count", 32'(pal0), 6);

        // Backpressure for several cycles in RESP.
        @(posedge clk);
        #3 rdy_mode = 2;
        wq[2].push_back(8'h3C);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus0.rsp_valid && n < 50);
        check("bp_rsp_timeout", 32'(n < 50), 1);
        repeat (5) @(posedge clk);
        #3 rdy_mode = 0;
        wait_drain("drain_bp", 100);

        // Reset one cycle after a grant.
        do_reset();
        wq[0].push_back(8'hA5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus0.req_ready[0] && n < 50);
        check("midwait_grant_timeout", 32'(n < 50), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        exp_gl = '{0, 1};
        wq[0].push_back(8'h66);
        wq[1].push_back(8'h99);
        wait_drain("drain_midwait", 100);
        check("midwait_total_count", 32'(tot0), 2);

        // Randomized traffic with random backpressure.
        rdy_mode = 1;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            #3;
            if ($urandom_range(0, 2) == 0) begin
                r = 8'($urandom);
                if ($urandom_range(0, 2) == 0) r = {r[0], r[1], r[2], r[3], r[3:0]};
                wq[$urandom_range(0, N0 - 1)].push_back(r);
            end
        end
        wait_drain("drain_random", 5000);
        @(posedge clk);
        #3 rdy_mode = 0;

        n = 0;
        while (!done1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("i1_done_timeout", 32'(done1), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
